// File: rtl/cpu_pkg.sv
// Shared definitions for the front-end branch sequencer: branch opcodes,
// flag bit positions inside the architectural flag word, and FSM states.
package cpu_pkg;

   // Decoded opcode width and the four conditional-branch encodings
   localparam int OP_W = 5;
   localparam logic [OP_W-1:0] OP_BEQ = 5'b10011;
   localparam logic [OP_W-1:0] OP_BLT = 5'b10100;
   localparam logic [OP_W-1:0] OP_BGT = 5'b10101;
   localparam logic [OP_W-1:0] OP_BNE = 5'b10110;

   // Architectural flag word layout: [1]=Z, [0]=N
   localparam int FLAGS_W = 2;
   localparam int Z_BIT   = 1;
   localparam int N_BIT   = 0;

   // Branch sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      EVAL  = 2'd2,
      FLUSH = 2'd3
   } br_state_t;

endpackage : cpu_pkg

// File: rtl/branch_cond_eval.sv
// Combinational branch decoder: reports whether an opcode is one of the
// conditional branches and whether its condition holds for the given flags.
module branch_cond_eval
   import cpu_pkg::*;
(
   input  logic [OP_W-1:0]    opcode,
   input  logic [FLAGS_W-1:0] flags,
   output logic               is_branch,
   output logic               taken
);

   // Decode opcode and evaluate its condition against Z/N
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      is_branch = 1'b1;
      taken     = 1'b0;
      case (opcode)
         OP_BEQ:  taken = flags[Z_BIT];
         OP_BNE:  taken = ~flags[Z_BIT];
         OP_BLT:  taken = flags[N_BIT];
         OP_BGT:  taken = ~flags[N_BIT];
         default: is_branch = 1'b0;
      endcase
   end

endmodule : branch_cond_eval

// File: rtl/branch_seq_ctrl.sv
// Conditional-branch sequencer for the CPU front end. Accepts a decoded
// branch, stalls fetch while a flag-writing op is still in flight, resolves
// the condition once flags are final, drives the PC redirect and holds the
// IF/ID flush for FLUSH_CYC cycles after a taken branch. Keeps saturating
// accepted/taken branch counters.
module branch_seq_ctrl
   import cpu_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int FLUSH_CYC = 2,
   parameter int WAIT_MAX  = 15,
   parameter int CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               br_valid,
   input  logic [OP_W-1:0]    opcode,
   input  logic [ADDR_W-1:0]  br_target,
   output logic               br_ready,
   input  logic               flag_pending,
   input  logic [FLAGS_W-1:0] flags,
   output logic               stall_fetch,
   output logic               pc_branch_sel,
   output logic [ADDR_W-1:0]  pc_target,
   output logic               flush_ifid,
   output logic               timeout_err,
   output logic [CNT_W-1:0]   br_total,
   output logic [CNT_W-1:0]   br_taken
);

   // Counter widths sized to hold the largest value each counter reaches
   localparam int WCW = $clog2(WAIT_MAX + 1);
   localparam int FCW = $clog2(FLUSH_CYC + 1);

   localparam logic [WCW-1:0]   WAIT_LAST = WCW'(WAIT_MAX - 1);
   localparam logic [FCW-1:0]   FLUSH_LD  = FCW'(FLUSH_CYC);
   localparam logic [FCW-1:0]   FLUSH_ONE = FCW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   br_state_t         state;
   logic [OP_W-1:0]   op_q;
   logic [ADDR_W-1:0] target_q;
   logic [WCW-1:0]    wait_cnt;
   logic [FCW-1:0]    flush_cnt;

   logic [OP_W-1:0]   eval_op;
   logic              is_branch;
   logic              cond_taken;
   logic              accept;
   logic              wait_expired;

   // One decoder serves both uses: the incoming opcode while idle (is it a
   // branch?) and the latched opcode afterwards (is it taken?).
   assign eval_op = (state == IDLE) ? opcode : op_q;

   branch_cond_eval u_cond (
      .opcode    (eval_op),
      .flags     (flags),
      .is_branch (is_branch),
      .taken     (cond_taken)
   );

   assign br_ready     = (state == IDLE);
   assign accept       = br_valid & br_ready & is_branch;
   assign wait_expired = (state == WAIT) & flag_pending & (wait_cnt == WAIT_LAST);

   // Redirect and timeout depend on this cycle's flags/pending, so they are
   // decoded from the current state rather than registered a cycle late.
   assign pc_branch_sel = (state == EVAL) & cond_taken;
   assign pc_target     = pc_branch_sel ? target_q : '0;
   assign timeout_err   = wait_expired;

   // Branch FSM with registered stall/flush outputs, op latches and counters
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state       <= IDLE;
         op_q        <= '0;
         target_q    <= '0;
         wait_cnt    <= '0;
         flush_cnt   <= '0;
         br_total    <= '0;
         br_taken    <= '0;
         stall_fetch <= 1'b0;
         flush_ifid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q        <= opcode;
                  target_q    <= br_target;
                  wait_cnt    <= '0;
                  stall_fetch <= 1'b1;
                  if (br_total != '1) br_total <= br_total + CNT_ONE;
                  state       <= flag_pending ? WAIT : EVAL;
               end
            end

            WAIT: begin
               if (!flag_pending) begin
                  wait_cnt <= '0;
                  state    <= EVAL;
               end else if (wait_expired) begin
                  // Flags never settled: drop the branch as not taken
                  wait_cnt    <= '0;
                  stall_fetch <= 1'b0;
                  state       <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + WCW'(1);
               end
            end

            EVAL: begin
               stall_fetch <= 1'b0;
               if (cond_taken) begin
                  if (br_taken != '1) br_taken <= br_taken + CNT_ONE;
                  flush_cnt  <= FLUSH_LD;
                  flush_ifid <= 1'b1;
                  state      <= FLUSH;
               end else begin
                  state <= IDLE;
               end
            end

            FLUSH: begin
               flush_cnt <= flush_cnt - FLUSH_ONE;
               if (flush_cnt == FLUSH_ONE) begin
                  flush_ifid <= 1'b0;
                  state      <= IDLE;
               end
            end

            default: begin
               stall_fetch <= 1'b0;
               flush_ifid  <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule : branch_seq_ctrl

// File: tb/tb_branch_seq_ctrl.sv
// Directed bench for branch_seq_ctrl: a cycle-by-cycle vector table for the
// main accept/evaluate/flush/wait flows plus hand-written sequences for the
// WAIT timeout, reset during FLUSH and counter saturation on a CNT_W=2 copy.
module tb_branch_seq_ctrl;
   import cpu_pkg::*;

   localparam int ADDR_W = 16;
   localparam int CNT_W  = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance (default parameters)
   logic              rst, br_valid, flag_pending;
   logic [OP_W-1:0]   opcode;
   logic [ADDR_W-1:0] br_target;
   logic [1:0]        flags;
   logic              br_ready, stall_fetch, pc_branch_sel, flush_ifid, timeout_err;
   logic [ADDR_W-1:0] pc_target;
   logic [CNT_W-1:0]  br_total, br_taken;

   // Small-counter instance (CNT_W=2) for saturation
   logic              rst_s, br_valid_s, flag_pending_s;
   logic [OP_W-1:0]   opcode_s;
   logic [ADDR_W-1:0] br_target_s;
   logic [1:0]        flags_s;
   logic              br_ready_s, stall_fetch_s, pc_branch_sel_s, flush_ifid_s, timeout_err_s;
   logic [ADDR_W-1:0] pc_target_s;
   logic [1:0]        br_total_s, br_taken_s;

   branch_seq_ctrl #(.ADDR_W(ADDR_W), .FLUSH_CYC(2), .WAIT_MAX(15), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .br_valid(br_valid), .opcode(opcode), .br_target(br_target),
      .br_ready(br_ready), .flag_pending(flag_pending), .flags(flags),
      .stall_fetch(stall_fetch), .pc_branch_sel(pc_branch_sel), .pc_target(pc_target),
      .flush_ifid(flush_ifid), .timeout_err(timeout_err),
      .br_total(br_total), .br_taken(br_taken)
   );

   branch_seq_ctrl #(.ADDR_W(ADDR_W), .FLUSH_CYC(2), .WAIT_MAX(15), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst_s), .br_valid(br_valid_s), .opcode(opcode_s), .br_target(br_target_s),
      .br_ready(br_ready_s), .flag_pending(flag_pending_s), .flags(flags_s),
      .stall_fetch(stall_fetch_s), .pc_branch_sel(pc_branch_sel_s), .pc_target(pc_target_s),
      .flush_ifid(flush_ifid_s), .timeout_err(timeout_err_s),
      .br_total(br_total_s), .br_taken(br_taken_s)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One table row: inputs held for one cycle, outputs expected in that cycle
   typedef struct {
      logic              valid;
      logic [OP_W-1:0]   op;
      logic [ADDR_W-1:0] tgt;
      logic              pend;
      logic [1:0]        flg;
      logic              e_ready;
      logic              e_stall;
      logic              e_sel;
      logic [ADDR_W-1:0] e_tgt;
      logic              e_flush;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] tgt,
                               input logic pend, input logic [1:0] flg,
                               input logic rdy, input logic stl, input logic sel,
                               input logic [ADDR_W-1:0] etgt, input logic fl);
      vec_t r;
      r.valid = v;   r.op = op;       r.tgt = tgt;   r.pend = pend;  r.flg = flg;
      r.e_ready = rdy; r.e_stall = stl; r.e_sel = sel; r.e_tgt = etgt; r.e_flush = fl;
      return r;
   endfunction

   localparam int NV = 16;
   vec_t vecs[NV];

   // Hard stop in case the stimulus itself stalls
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int fire;
      int stall_cnt;
      int n;

      //          valid  op      tgt      pend  flg    rdy  stl  sel  etgt     flush
      // BEQ taken with Z=1: EVAL redirect, then two flush cycles
      vecs[0]  = mk(1'b1, OP_BEQ, 16'h0040, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      vecs[1]  = mk(1'b1, OP_BNE, 16'h0bad, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 16'h0040, 1'b0);
      vecs[2]  = mk(1'b0, OP_BEQ, 16'h0000, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      vecs[3]  = mk(1'b0, OP_BEQ, 16'h0000, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      // BGT with N=1: not taken, no flush, idle after one EVAL cycle
      vecs[4]  = mk(1'b1, OP_BGT, 16'h0080, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      vecs[5]  = mk(1'b0, OP_BGT, 16'h0000, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
      // BLT with flags pending for 4 cycles, then N=1: 5 stall cycles, taken
      vecs[6]  = mk(1'b1, OP_BLT, 16'h1234, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      vecs[7]  = mk(1'b0, OP_BLT, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
      vecs[8]  = mk(1'b0, OP_BLT, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
      vecs[9]  = mk(1'b0, OP_BLT, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
      vecs[10] = mk(1'b0, OP_BLT, 16'h0000, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
      vecs[11] = mk(1'b0, OP_BLT, 16'h0000, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0);
      vecs[12] = mk(1'b0, OP_BLT, 16'h0000, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      vecs[13] = mk(1'b0, OP_BLT, 16'h0000, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      // Non-branch opcode with br_valid: must not be accepted
      vecs[14] = mk(1'b1, 5'b00001, 16'h0055, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      vecs[15] = mk(1'b0, 5'b00001, 16'h0000, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);

      rst = 1'b1; br_valid = 1'b0; opcode = '0; br_target = '0; flag_pending = 1'b0; flags = '0;
      rst_s = 1'b1; br_valid_s = 1'b0; opcode_s = '0; br_target_s = '0;
      flag_pending_s = 1'b0; flags_s = 2'b10;

      // Reset held for 3 cycles: every output low
      repeat (3) tick();
      check("rst stall_fetch", stall_fetch, 0);
      check("rst pc_branch_sel", pc_branch_sel, 0);
      check("rst pc_target", pc_target, 0);
      check("rst flush_ifid", flush_ifid, 0);
      check("rst timeout_err", timeout_err, 0);
      check("rst br_total", br_total, 0);
      check("rst br_taken", br_taken, 0);
      rst = 1'b0;
      rst_s = 1'b0;
      #2;
      check("post-rst br_ready", br_ready, 1);

      // Table-driven main flows
      for (int i = 0; i < NV; i++) begin
         br_valid = vecs[i].valid; opcode = vecs[i].op; br_target = vecs[i].tgt;
         flag_pending = vecs[i].pend; flags = vecs[i].flg;
         #2;
         check($sformatf("row%0d br_ready", i), br_ready, vecs[i].e_ready);
         check($sformatf("row%0d stall_fetch", i), stall_fetch, vecs[i].e_stall);
         check($sformatf("row%0d pc_branch_sel", i), pc_branch_sel, vecs[i].e_sel);
         check($sformatf("row%0d pc_target", i), pc_target, vecs[i].e_tgt);
         check($sformatf("row%0d flush_ifid", i), flush_ifid, vecs[i].e_flush);
         check($sformatf("row%0d timeout_err", i), timeout_err, 0);
         tick();
      end
      br_valid = 1'b0;
      // BEQ, BGT, BLT accepted; BEQ and BLT taken
      check("table br_total", br_total, 3);
      check("table br_taken", br_taken, 2);

      // BNE with flags never settling: timeout in the 15th WAIT cycle
      br_valid = 1'b1; opcode = OP_BNE; br_target = 16'h0100; flag_pending = 1'b1; flags = 2'b00;
      #2;
      tick();
      br_valid = 1'b0;
      fire = 0;
      stall_cnt = 0;
      for (int c = 1; c <= 20; c++) begin
         #2;
         if (br_ready) break;
         if (stall_fetch) stall_cnt++;
         if (timeout_err && fire == 0) fire = c;
         tick();
      end
      check("timeout cycle", fire, 15);
      check("timeout stall cycles", stall_cnt, 15);
      check("timeout br_ready", br_ready, 1);
      check("timeout pulse ended", timeout_err, 0);
      check("timeout no redirect", pc_branch_sel, 0);
      check("timeout br_total", br_total, 4);
      check("timeout br_taken", br_taken, 2);
      tick();
      flag_pending = 1'b0;

      // Reset in the middle of FLUSH abandons the flush
      br_valid = 1'b1; opcode = OP_BEQ; br_target = 16'h0200; flags = 2'b10;
      #2;
      tick();
      br_valid = 1'b0;
      #2;
      check("midflush eval sel", pc_branch_sel, 1);
      tick();
      #2;
      check("midflush flushing", flush_ifid, 1);
      rst = 1'b1;
      tick();
      #2;
      check("midflush rst flush_ifid", flush_ifid, 0);
      check("midflush rst stall_fetch", stall_fetch, 0);
      check("midflush rst br_ready", br_ready, 1);
      check("midflush rst br_total", br_total, 0);
      check("midflush rst br_taken", br_taken, 0);
      rst = 1'b0;
      tick();

      // CNT_W=2 copy: five taken branches, counters stick at 3
      for (int k = 0; k < 5; k++) begin
         n = 0;
         while (!br_ready_s && n < 20) begin
            tick();
            n++;
         end
         check($sformatf("sat ready%0d", k), br_ready_s, 1);
         br_valid_s = 1'b1; opcode_s = OP_BEQ; br_target_s = 16'h0300;
         #2;
         tick();
         br_valid_s = 1'b0;
      end
      n = 0;
      while (!br_ready_s && n < 20) begin
         tick();
         n++;
      end
      check("sat final ready", br_ready_s, 1);
      check("sat br_taken", br_taken_s, 3);
      check("sat br_total", br_total_s, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_branch_seq_ctrl
